// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the execute-stage sequencer and its ALU.
package alu_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE} seq_state_t;

  localparam logic [1:0] MODE_LOADI = 2'b00;
  localparam logic [1:0] MODE_ALU   = 2'b01;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] rsvd;
    logic [2:0] op;
  } instr_t;

  function automatic logic is_legal_alu_op(input logic [2:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command handshake from instruction decode into the sequencer.
interface alu_sequencer_if #(parameter int REG_AW = 2);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_instr;
  logic [REG_AW-1:0] cmd_dst;
  logic [REG_AW-1:0] cmd_src_a;
  logic [REG_AW-1:0] cmd_src_b;
  logic [7:0]        cmd_imm;

  modport master (output cmd_valid, cmd_instr, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_instr, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
                  output cmd_ready);
endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x 8 register file: one sync write port, two operand reads, one debug read.
module alu_regfile #(
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  logic [NUM_REGS-1:0][7:0] regs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  regs        <= '0;
    else if (we)   regs[waddr] <= wdata;
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage controller: accepts one command, drives the clocked ALU,
// waits out its latency, writes back and updates zero/negative flags.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int ALU_LATENCY = 1,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  alu_sequencer_if.slave    cmd,
  output logic [2:0]        alu_opcode,
  output logic [7:0]        alu_operand_a,
  output logic [7:0]        alu_operand_b,
  input  logic [7:0]        alu_result,
  output logic              done,
  output logic              error,
  output logic              flag_zero,
  output logic              flag_negative,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  seq_state_t        state;
  logic [2:0]        cnt;
  logic [REG_AW-1:0] dst_q;
  instr_t            ins;
  logic              accept, is_loadi, is_alu;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [7:0]        wdata, rd_a, rd_b;
  logic              unused_rsvd;

  assign ins         = instr_t'(cmd.cmd_instr);
  assign unused_rsvd = ^ins.rsvd;
  assign cmd.cmd_ready = (state == IDLE);
  assign accept      = cmd.cmd_valid & cmd.cmd_ready;
  assign is_loadi    = (ins.mode == MODE_LOADI);
  assign is_alu      = (ins.mode == MODE_ALU) && is_legal_alu_op(ins.op);

  // LOADI writes at the accept edge; ALU results write at the WRITE edge.
  always_comb begin
    we    = 1'b0;
    waddr = cmd.cmd_dst;
    wdata = cmd.cmd_imm;
    if (state == WRITE) begin
      we    = 1'b1;
      waddr = dst_q;
      wdata = alu_result;
    end else if (accept && is_loadi) begin
      we    = 1'b1;
    end
  end

  alu_regfile #(.NUM_REGS(NUM_REGS), .AW(REG_AW)) u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (cmd.cmd_src_a),
    .rdata_a  (rd_a),
    .raddr_b  (cmd.cmd_src_b),
    .rdata_b  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dst_q         <= '0;
      alu_opcode    <= 3'b000;
      alu_operand_a <= 8'h00;
      alu_operand_b <= 8'h00;
      done          <= 1'b0;
      error         <= 1'b0;
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_loadi) begin
            done <= 1'b1;
          end else if (is_alu) begin
            // Operands captured now, so dst aliasing a source sees pre-write values.
            alu_opcode    <= ins.op;
            alu_operand_a <= rd_a;
            alu_operand_b <= rd_b;
            dst_q         <= cmd.cmd_dst;
            cnt           <= 3'(ALU_LATENCY);
            state         <= ISSUE;
          end else begin
            done  <= 1'b1;
            error <= 1'b1;
          end
        end
        ISSUE: begin
          if (cnt == 3'd1) state <= WRITE;
          else             cnt   <= cnt - 3'd1;
        end
        WRITE: begin
          flag_zero     <= (alu_result == 8'h00);
          flag_negative <= alu_result[7];
          done          <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer at ALU_LATENCY=1 and 3, each with a clocked ALU model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic       sel = 1'b0, valid = 1'b0;
  logic [7:0] instr = '0, imm = '0;
  logic [1:0] dst = '0, sa = '0, sb = '0, dbg_addr = '0;

  alu_sequencer_if #(.REG_AW(2)) c1();
  alu_sequencer_if #(.REG_AW(2)) c3();

  assign c1.cmd_valid = valid & ~sel;
  assign c1.cmd_instr = instr;
  assign c1.cmd_dst   = dst;
  assign c1.cmd_src_a = sa;
  assign c1.cmd_src_b = sb;
  assign c1.cmd_imm   = imm;
  assign c3.cmd_valid = valid & sel;
  assign c3.cmd_instr = instr;
  assign c3.cmd_dst   = dst;
  assign c3.cmd_src_a = sa;
  assign c3.cmd_src_b = sb;
  assign c3.cmd_imm   = imm;

  logic [2:0] op1, op3;
  logic [7:0] a1, b1, a3, b3, res1, dbg1, dbg3;
  logic [7:0] p3_0, p3_1, p3_2;
  logic       done1, err1, zf1, nf1, done3, err3, zf3, nf3;

  alu_sequencer #(.NUM_REGS(4), .ALU_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .cmd(c1.slave),
    .alu_opcode(op1), .alu_operand_a(a1), .alu_operand_b(b1), .alu_result(res1),
    .done(done1), .error(err1), .flag_zero(zf1), .flag_negative(nf1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1));

  alu_sequencer #(.NUM_REGS(4), .ALU_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .cmd(c3.slave),
    .alu_opcode(op3), .alu_operand_a(a3), .alu_operand_b(b3), .alu_result(p3_2),
    .done(done3), .error(err3), .flag_zero(zf3), .flag_negative(nf3),
    .dbg_addr(dbg_addr), .dbg_data(dbg3));

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a & b);
      3'b011:  return ~(a | b);
      3'b100:  return a + b;
      3'b101:  return a - b;
      default: return 8'h00;
    endcase
  endfunction

  // Downstream ALU models: result valid ALU_LATENCY edges after inputs settle.
  always @(posedge clock) res1 <= alu_f(op1, a1, b1);
  always @(posedge clock) begin
    p3_0 <= alu_f(op3, a3, b3);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  logic       done_m, err_m, ready_m, zf_m, nf_m;
  logic [2:0] op_m;
  logic [7:0] dbg_m;
  assign done_m  = sel ? done3 : done1;
  assign err_m   = sel ? err3  : err1;
  assign ready_m = sel ? c3.cmd_ready : c1.cmd_ready;
  assign zf_m    = sel ? zf3   : zf1;
  assign nf_m    = sel ? nf3   : nf1;
  assign op_m    = sel ? op3   : op1;
  assign dbg_m   = sel ? dbg3  : dbg1;

  // Issue one command from IDLE; report edges from accept to done inclusive.
  task automatic do_cmd(input logic [7:0] i, input logic [1:0] d, input logic [1:0] s_a,
                        input logic [1:0] s_b, input logic [7:0] im,
                        output int edges, output logic err, output logic held);
    instr = i; dst = d; sa = s_a; sb = s_b; imm = im; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0; edges = 1; held = 1'b1;
    while (done_m !== 1'b1 && edges < 20) begin
      if (op_m !== i[2:0]) held = 1'b0;
      @(posedge clock); #1;
      edges++;
    end
    err = err_m;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    dbg_addr = a; #1; v = dbg_m;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({done1, err1, zf1, nf1} !== 4'b0) begin failures++; $display("FAIL reset_pulses_flags: got %b want 0000", {done1, err1, zf1, nf1}); end
    checks++; if ({op1, a1, b1} !== 19'h0) begin failures++; $display("FAIL reset_alu_outs: got op=%b a=%h b=%h want 0", op1, a1, b1); end
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_reg%0d: got %h want 00", r, v); end
    end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if ({c1.cmd_ready, c3.cmd_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready: got %b want 11", {c1.cmd_ready, c3.cmd_ready}); end
  endtask

  task automatic test_loadi;
    int e; logic er, h; logic [7:0] v;
    do_cmd(8'h00, 2'd1, 2'd0, 2'd0, 8'h7F, e, er, h);
    checks++; if (e !== 1 || er !== 1'b0) begin failures++; $display("FAIL loadi_r1_latency: got edges=%0d err=%b want 1 0", e, er); end
    @(posedge clock); #1;
    checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL loadi_done_one_cycle: got %b want 0", done_m); end
    do_cmd(8'h00, 2'd2, 2'd0, 2'd0, 8'h01, e, er, h);
    checks++; if (e !== 1) begin failures++; $display("FAIL loadi_r2_latency: got %0d want 1", e); end
    rd(2'd1, v);
    checks++; if (v !== 8'h7F) begin failures++; $display("FAIL loadi_r1: got %h want 7f", v); end
    rd(2'd2, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL loadi_r2: got %h want 01", v); end
    checks++; if ({zf_m, nf_m} !== 2'b00) begin failures++; $display("FAIL loadi_flags: got %b want 00", {zf_m, nf_m}); end
  endtask

  task automatic test_alu_add;
    int e; logic er, h; logic [7:0] v;
    do_cmd(8'h44, 2'd3, 2'd1, 2'd2, 8'h00, e, er, h);
    checks++; if (e !== 3 || er !== 1'b0) begin failures++; $display("FAIL add_latency: got edges=%0d err=%b want 3 0", e, er); end
    checks++; if (h !== 1'b1) begin failures++; $display("FAIL add_opcode_held: got held=%b want 1", h); end
    @(posedge clock); #1;
    rd(2'd3, v);
    checks++; if (v !== 8'h80) begin failures++; $display("FAIL add_r3: got %h want 80", v); end
    checks++; if ({zf_m, nf_m} !== 2'b01) begin failures++; $display("FAIL add_flags: got zf,nf=%b want 01", {zf_m, nf_m}); end
  endtask

  task automatic test_sub_wrap;
    int e; logic er, h; logic [7:0] v;
    do_cmd(8'h00, 2'd0, 2'd0, 2'd0, 8'h05, e, er, h);
    do_cmd(8'h45, 2'd0, 2'd0, 2'd0, 8'h00, e, er, h);
    rd(2'd0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL sub_self_r0: got %h want 00", v); end
    checks++; if ({zf_m, nf_m} !== 2'b10) begin failures++; $display("FAIL sub_flags: got zf,nf=%b want 10", {zf_m, nf_m}); end
    do_cmd(8'h00, 2'd1, 2'd0, 2'd0, 8'hFF, e, er, h);
    do_cmd(8'h44, 2'd3, 2'd1, 2'd2, 8'h00, e, er, h);
    rd(2'd3, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL add_wrap_r3: got %h want 00", v); end
    checks++; if ({zf_m, nf_m} !== 2'b10) begin failures++; $display("FAIL add_wrap_flags: got zf,nf=%b want 10", {zf_m, nf_m}); end
  endtask

  task automatic test_illegal;
    int e; logic er, h; logic [7:0] v;
    logic [7:0] exp_r [4];
    exp_r = '{8'h00, 8'hFF, 8'h01, 8'h00};
    do_cmd(8'h46, 2'd0, 2'd1, 2'd2, 8'h00, e, er, h);
    checks++; if (e !== 1 || er !== 1'b1) begin failures++; $display("FAIL illegal_op110: got edges=%0d err=%b want 1 1", e, er); end
    @(posedge clock); #1;
    checks++; if ({done_m, err_m} !== 2'b00) begin failures++; $display("FAIL illegal_pulse_end: got %b want 00", {done_m, err_m}); end
    do_cmd(8'h80, 2'd1, 2'd1, 2'd2, 8'h55, e, er, h);
    checks++; if (e !== 1 || er !== 1'b1) begin failures++; $display("FAIL illegal_mode10: got edges=%0d err=%b want 1 1", e, er); end
    checks++; if ({zf_m, nf_m} !== 2'b10) begin failures++; $display("FAIL illegal_flags: got %b want 10", {zf_m, nf_m}); end
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      checks++; if (v !== exp_r[r]) begin failures++; $display("FAIL illegal_reg%0d: got %h want %h", r, v, exp_r[r]); end
    end
  endtask

  task automatic test_back_to_back(input logic s);
    int e, n, last, ndone, gap; logic er, h; logic [7:0] v;
    logic [7:0] ci [3];
    logic [1:0] cd [3], ca [3], cb [3];
    logic [7:0] exp_r [4];
    ci = '{8'h41, 8'h44, 8'h42};
    cd = '{2'd0, 2'd3, 2'd2};
    ca = '{2'd1, 2'd0, 2'd3};
    cb = '{2'd2, 2'd1, 2'd1};
    exp_r = '{8'hFF, 8'h0F, 8'hF1, 8'h0E};
    gap = s ? 5 : 3;
    sel = s; #1;
    do_cmd(8'h00, 2'd1, 2'd0, 2'd0, 8'h0F, e, er, h);
    do_cmd(8'h00, 2'd2, 2'd0, 2'd0, 8'hF0, e, er, h);
    instr = ci[0]; dst = cd[0]; sa = ca[0]; sb = cb[0]; valid = 1'b1;
    n = 0; last = 0; ndone = 0;
    while (ndone < 3 && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done_m === 1'b1) begin
        checks++; if (n - last !== gap) begin failures++; $display("FAIL b2b_gap_lat%0d: got %0d want %0d", gap - 2, n - last, gap); end
        last = n; ndone++;
        if (ndone < 3) begin instr = ci[ndone]; dst = cd[ndone]; sa = ca[ndone]; sb = cb[ndone]; end
        else valid = 1'b0;
      end else begin
        checks++; if (ready_m !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy: got %b want 0 at edge %0d", ready_m, n); end
      end
    end
    valid = 1'b0;
    checks++; if (ndone !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      checks++; if (v !== exp_r[r]) begin failures++; $display("FAIL b2b_reg%0d_lat%0d: got %h want %h", r, gap - 2, v, exp_r[r]); end
    end
    checks++; if ({zf_m, nf_m} !== 2'b01) begin failures++; $display("FAIL b2b_flags: got %b want 01", {zf_m, nf_m}); end
    @(posedge clock); #1;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] v; int pulses;
    instr = 8'h42; dst = 2'd0; sa = 2'd1; sb = 2'd2; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    checks++; if (op1 !== OP_NAND || c1.cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_in_issue: got op=%b ready=%b want 010 0", op1, c1.cmd_ready); end
    reset_n = 1'b0; #1;
    checks++; if ({done1, err1, zf1, nf1, op1, a1, b1} !== 23'h0) begin failures++; $display("FAIL mid_reset_outs: got d=%b e=%b z=%b n=%b op=%b a=%h b=%h want 0", done1, err1, zf1, nf1, op1, a1, b1); end
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_reset_reg%0d: got %h want 00", r, v); end
    end
    @(negedge clock); reset_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done1 === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || c1.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_no_done: got pulses=%0d ready=%b want 0 1", pulses, c1.cmd_ready); end
    rd(2'd0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_no_writeback: got %h want 00", v); end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_alu_add();
    test_sub_wrap();
    test_illegal();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-stage controller for the 8-bit CPU. Accepts one decoded command at a time over a valid/ready handshake and owns a small register file.
- Drives the clocked ALU's opcode and operand inputs, waits out the ALU's registered latency, then writes the result back and updates the zero/negative flags.
- Sits between instruction decode (upstream) and the existing ALU instance (downstream, external to this block).

Parameters:
- NUM_REGS, 4, number of 8-bit general registers; power of two, at least 2; REG_AW = $clog2(NUM_REGS).
- ALU_LATENCY, 1, clock edges between stable ALU inputs and a valid alu_result; range 1..7.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_instr  input  8  [7:6] mode, [5:3] ignored, [2:0] ALU op.
- cmd_dst  input  REG_AW  destination register.
- cmd_src_a  input  REG_AW  operand A register.
- cmd_src_b  input  REG_AW  operand B register.
- cmd_imm  input  8  immediate for LOADI.
- alu_opcode  output  3  to ALU opcode.
- alu_operand_a  output  8  to ALU operandA.
- alu_operand_b  output  8  to ALU operandB.
- alu_result  input  8  from ALU result.
- done  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse, coincident with done, for an illegal command.
- flag_zero  output  1  last ALU result == 0.
- flag_negative  output  1  last ALU result bit 7.
- dbg_addr  input  REG_AW  register read address.
- dbg_data  output  8  combinational read of regs[dbg_addr].

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all regs = 0x00.
  - alu_opcode=3'b000; alu_operand_a/b=0.
  - done=error=flag_zero=flag_negative=0; cmd_ready=1 after reset releases.
  - Reset mid-operation abandons the command: no writeback, no done.
- Modes:
  - 00 = LOADI: regs[dst] <= imm.
  - 01 = ALU.
  - 10, 11 = illegal.
  - ALU ops 000 AND, 001 OR, 010 NAND, 011 NOR, 100 ADD, 101 SUB; 110 and 111 are illegal.
- States: IDLE, ISSUE, WRITE.
- IDLE:
  - cmd_ready=1. Accept when cmd_valid & cmd_ready at a rising edge.
  - LOADI: write regs[dst] at the accept edge; done pulses the next cycle; stay IDLE. Flags are unchanged.
  - Illegal: no register or flag change; done=error=1 the next cycle; stay IDLE.
  - Legal ALU: latch opcode, regs[src_a] and regs[src_b] into the alu_* outputs; load wait counter = ALU_LATENCY; go to ISSUE.
- ISSUE:
  - cmd_ready=0; alu_* outputs held constant.
  - Counter decrements each edge; at count 1 go to WRITE.
- WRITE (one cycle):
  - alu_result is valid. At the edge: regs[dst] <= alu_result; flag_zero <= (alu_result==0); flag_negative <= alu_result[7]; go to IDLE.
  - done pulses in the first IDLE cycle.
- Latency, accept edge to done high:
  - LOADI and illegal: 1 cycle.
  - ALU: ALU_LATENCY+2 cycles (3 at default).
- Throughput: a new command may be accepted in the same cycle done is high.
- Operands are latched at accept, so dst equal to a src, or src_a==src_b, is legal and reads pre-write values.
- dbg_data reflects a write from the cycle after the write edge.
- Arithmetic is 8-bit two's complement and wraps; the sequencer neither adds nor checks carry/overflow.
- cmd_* inputs are ignored while cmd_ready=0.
- done and error are never high outside the one-cycle pulse.

Decomposition:
- Package alu_seq_pkg:
  - typedef enum logic[1:0] {IDLE, ISSUE, WRITE} seq_state_t.
  - Mode constants MODE_LOADI=2'b00, MODE_ALU=2'b01.
  - Opcode constants OP_AND..OP_SUB shared with the ALU.
  - Function is_legal_alu_op().
- Sub-module alu_regfile: NUM_REGS x 8, one synchronous write port, two read ports for operand latch, one debug read port, async active-low clear.

Test Plan:
- Reset then LOADI r1=0x7F, LOADI r2=0x01 -> each done 1 cycle after accept; dbg_data(r1)=0x7F, (r2)=0x01.
- ALU ADD(100) dst=r3, a=r1, b=r2 -> alu_opcode=100 held through ISSUE; done 3 cycles after accept; r3=0x80; flag_negative=1, flag_zero=0.
- r0=0x05; SUB(101) dst=r0, a=r0, b=r0 -> r0=0x00; flag_zero=1; ADD 0xFF+0x01 wraps to 0x00 with flag_zero=1.
- Illegal: instr 0x46 (op 110) and 0x80 (mode 10) -> done=error=1 after 1 cycle; registers and flags unchanged.
- Back-to-back: cmd_valid held high with 3 ALU commands -> accepted on done cycles; cmd_ready=0 in ISSUE/WRITE; all writebacks correct; repeat with ALU_LATENCY=3 -> done 5 cycles after accept.
- Assert reset_n low in ISSUE of NAND r1,r2 -> immediately all outputs and regs 0, state IDLE; no done pulse after release.
